// File: rtl/decode_issue_ctrl.sv
// Issue sequencer between fetch and execute: holds one instruction, tracks pending register
// writes in a scoreboard and stalls issue on RAW/WAW hazards until writeback clears them.
module decode_issue_ctrl #(
  parameter int unsigned XLEN              = 32,
  parameter int unsigned REG_FILE_DEPTH    = 32,
  parameter int unsigned REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH),
  parameter int unsigned STALL_CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [XLEN-1:0]              if_instr,
  input  logic                         flush,
  input  logic                         wb_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0] wb_rd,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [XLEN-1:0]              iss_instr,
  output logic [REG_FILE_ADDR_LEN-1:0] iss_rs1,
  output logic [REG_FILE_ADDR_LEN-1:0] iss_rs2,
  output logic [REG_FILE_ADDR_LEN-1:0] iss_rd,
  output logic                         iss_illegal,
  output logic [REG_FILE_DEPTH-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  logic                         hold_valid_q, hold_valid_d;
  logic [XLEN-1:0]              hold_instr_q, hold_instr_d;
  logic [REG_FILE_DEPTH-1:0]    busy_q, busy_d;
  logic [STALL_CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic                         use_rs1, use_rs2, use_rd, illegal;
  logic [REG_FILE_ADDR_LEN-1:0] rs1_f, rs2_f, rd_f;
  logic                         hazard, issue;

  assign rs1_f = hold_instr_q[15 +: REG_FILE_ADDR_LEN];
  assign rs2_f = hold_instr_q[20 +: REG_FILE_ADDR_LEN];
  assign rd_f  = hold_instr_q[7 +: REG_FILE_ADDR_LEN];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    case (hold_instr_q[6:0])
      OpLui, OpAuipc, OpJal:  use_rd = 1'b1;
      OpJalr, OpLoad, OpImm: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OpBranch, OpStore: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OpReg: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OpMiscMem, OpSystem: ;
      default: illegal = 1'b1;
    endcase
  end

  // x0 never hazards and is never marked pending
  always_comb begin
    hazard = 1'b0;
    if (use_rs1 && rs1_f != '0 && busy_q[rs1_f]) hazard = 1'b1;
    if (use_rs2 && rs2_f != '0 && busy_q[rs2_f]) hazard = 1'b1;
    if (use_rd && rd_f != '0 && busy_q[rd_f])    hazard = 1'b1;
  end

  assign iss_valid   = hold_valid_q & ~hazard & ~flush;
  assign issue       = iss_valid & iss_ready;
  assign if_ready    = ~flush & (~hold_valid_q | issue);
  assign iss_instr   = hold_instr_q;
  assign iss_rs1     = use_rs1 ? rs1_f : '0;
  assign iss_rs2     = use_rs2 ? rs2_f : '0;
  assign iss_rd      = use_rd ? rd_f : '0;
  assign iss_illegal = hold_valid_q & illegal;
  assign busy_mask   = busy_q;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    busy_d       = busy_q;
    stall_cnt_d  = stall_cnt_q;

    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (if_ready) begin
      hold_valid_d = if_valid;
      if (if_valid) hold_instr_d = if_instr;
    end

    // Clear first so an issue setting the same register wins
    if (wb_valid && wb_rd != '0) busy_d[wb_rd] = 1'b0;
    if (issue && use_rd && rd_f != '0) busy_d[rd_f] = 1'b1;

    if (hold_valid_q && hazard && !flush && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      busy_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      busy_q       <= busy_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule
